// File: rtl/dmw_pkg.sv
// Shared field layout, writable mask and MAT encodings for the LoongArch
// direct-mapped configuration windows.
package dmw_pkg;

  localparam int unsigned VSEG_HI  = 31;
  localparam int unsigned VSEG_LO  = 29;
  localparam int unsigned PSEG_HI  = 27;
  localparam int unsigned PSEG_LO  = 25;
  localparam int unsigned MAT_HI   = 5;
  localparam int unsigned MAT_LO   = 4;
  localparam int unsigned PLV3_BIT = 3;
  localparam int unsigned PLV0_BIT = 0;

  localparam logic [31:0] DMW_WMASK = 32'hEE00_0039;

  typedef enum logic [1:0] {
    MAT_SUC = 2'd0,
    MAT_CC  = 2'd1
  } mat_e;

endpackage

// File: rtl/dmw_match.sv
// Combinational match of one window against a virtual segment and privilege
// level; also extracts the physical segment and memory type of the window.
module dmw_match
  import dmw_pkg::*;
(
  input  logic [31:0] win,
  input  logic [2:0]  vseg,
  input  logic [1:0]  plv,
  output logic        hit,
  output logic [2:0]  paddr_hi,
  output logic [1:0]  mat
);

  logic plv_ok;
  logic unused;

  // PLV1/PLV2 have no enable bit in the window, so they can never match.
  assign plv_ok   = ((plv == 2'd0) && win[PLV0_BIT]) ||
                    ((plv == 2'd3) && win[PLV3_BIT]);
  assign hit      = plv_ok && (win[VSEG_HI:VSEG_LO] == vseg);
  assign paddr_hi = win[PSEG_HI:PSEG_LO];
  assign mat      = win[MAT_HI:MAT_LO];

  assign unused = ^{win[28], win[24:6], win[2:1]};

endmodule

// File: rtl/dmw_array.sv
// Bank of NUM_DMW direct-mapped windows: CSR write/read with a registered
// read path, and a one-stage pipelined address translation port.
module dmw_array
  import dmw_pkg::*;
#(
  parameter int          NUM_DMW = 2,
  parameter int          IDX_W   = (NUM_DMW > 1) ? $clog2(NUM_DMW) : 1,
  parameter logic [31:0] WMASK   = DMW_WMASK
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  csr_we,
  input  logic [IDX_W-1:0]      csr_widx,
  input  logic [31:0]           csr_wdata,
  input  logic                  csr_re,
  input  logic [IDX_W-1:0]      csr_ridx,
  output logic [31:0]           csr_rdata,
  output logic                  csr_rvalid,
  output logic [32*NUM_DMW-1:0] dmw_flat,
  input  logic                  req_valid,
  input  logic [31:0]           req_vaddr,
  input  logic [1:0]            req_plv,
  input  logic                  flush,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic                  resp_multi,
  output logic [IDX_W-1:0]      resp_idx,
  output logic [31:0]           resp_paddr,
  output logic [1:0]            resp_mat
);

  logic [31:0]      win [NUM_DMW];
  logic [31:0]      wmasked;
  logic [31:0]      rd_next;
  logic [NUM_DMW-1:0] hits;
  logic [2:0]       phi [NUM_DMW];
  logic [1:0]       mats [NUM_DMW];
  logic             any_hit;
  logic             multi;
  logic [IDX_W-1:0] sel_idx;
  logic [2:0]       sel_phi;
  logic [1:0]       sel_mat;
  logic [3:0]       hit_cnt;

  assign wmasked = csr_wdata & WMASK;

  // Indices >= NUM_DMW never compare equal to a loop index, so out-of-range
  // writes fall through naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_DMW; i++) win[i] <= '0;
    end else if (csr_we) begin
      for (int unsigned i = 0; i < NUM_DMW; i++)
        if (csr_widx == IDX_W'(i)) win[i] <= wmasked;
    end
  end

  for (genvar g = 0; g < NUM_DMW; g++) begin : g_win
    assign dmw_flat[32*g +: 32] = win[g];

    dmw_match u_match (
      .win      (win[g]),
      .vseg     (req_vaddr[31:29]),
      .plv      (req_plv),
      .hit      (hits[g]),
      .paddr_hi (phi[g]),
      .mat      (mats[g])
    );
  end

  // Write-first read mux; out-of-range indices select nothing and read 0.
  always_comb begin
    rd_next = '0;
    for (int unsigned i = 0; i < NUM_DMW; i++)
      if (csr_ridx == IDX_W'(i))
        rd_next = (csr_we && (csr_widx == csr_ridx)) ? wmasked : win[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csr_rvalid <= 1'b0;
      csr_rdata  <= '0;
    end else begin
      csr_rvalid <= csr_re;
      if (csr_re) csr_rdata <= rd_next;
    end
  end

  // Lowest-index priority encode plus hit population count.
  always_comb begin
    any_hit = 1'b0;
    sel_idx = '0;
    sel_phi = '0;
    sel_mat = '0;
    hit_cnt = '0;
    for (int unsigned i = 0; i < NUM_DMW; i++) begin
      if (hits[i]) begin
        hit_cnt = hit_cnt + 4'd1;
        if (!any_hit) begin
          any_hit = 1'b1;
          sel_idx = IDX_W'(i);
          sel_phi = phi[i];
          sel_mat = mats[i];
        end
      end
    end
    multi = (hit_cnt > 4'd1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_multi <= 1'b0;
      resp_idx   <= '0;
      resp_paddr <= '0;
      resp_mat   <= '0;
    end else begin
      resp_valid <= req_valid & ~flush;
      if (req_valid && !flush) begin
        resp_hit   <= any_hit;
        resp_multi <= multi;
        resp_idx   <= sel_idx;
        resp_paddr <= any_hit ? {sel_phi, req_vaddr[28:0]} : req_vaddr;
        resp_mat   <= any_hit ? sel_mat : 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_dmw_array.sv
// Directed bench for dmw_array with three windows, so that index 3 is an
// out-of-range CSR index.
module tb_dmw_array;

  localparam int N  = 3;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            csr_we;
  logic [IW-1:0]   csr_widx;
  logic [31:0]     csr_wdata;
  logic            csr_re;
  logic [IW-1:0]   csr_ridx;
  logic [31:0]     csr_rdata;
  logic            csr_rvalid;
  logic [32*N-1:0] dmw_flat;
  logic            req_valid;
  logic [31:0]     req_vaddr;
  logic [1:0]      req_plv;
  logic            flush;
  logic            resp_valid;
  logic            resp_hit;
  logic            resp_multi;
  logic [IW-1:0]   resp_idx;
  logic [31:0]     resp_paddr;
  logic [1:0]      resp_mat;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmw_array #(.NUM_DMW(N), .IDX_W(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .csr_we     (csr_we),
    .csr_widx   (csr_widx),
    .csr_wdata  (csr_wdata),
    .csr_re     (csr_re),
    .csr_ridx   (csr_ridx),
    .csr_rdata  (csr_rdata),
    .csr_rvalid (csr_rvalid),
    .dmw_flat   (dmw_flat),
    .req_valid  (req_valid),
    .req_vaddr  (req_vaddr),
    .req_plv    (req_plv),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_hit   (resp_hit),
    .resp_multi (resp_multi),
    .resp_idx   (resp_idx),
    .resp_paddr (resp_paddr),
    .resp_mat   (resp_mat)
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resp(input string tag, input logic v, input logic h, input logic m,
                      input logic [IW-1:0] idx, input logic [31:0] pa, input logic [1:0] mat);
    chk({tag, ".valid"}, 96'(resp_valid), 96'(v));
    chk({tag, ".hit"},   96'(resp_hit),   96'(h));
    chk({tag, ".multi"}, 96'(resp_multi), 96'(m));
    chk({tag, ".idx"},   96'(resp_idx),   96'(idx));
    chk({tag, ".paddr"}, 96'(resp_paddr), 96'(pa));
    chk({tag, ".mat"},   96'(resp_mat),   96'(mat));
  endtask

  task automatic wr(input logic [IW-1:0] idx, input logic [31:0] d);
    csr_we = 1'b1; csr_widx = idx; csr_wdata = d;
    step();
    csr_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; csr_we = 0; csr_widx = 0; csr_wdata = 0; csr_re = 0; csr_ridx = 0;
    req_valid = 0; req_vaddr = 0; req_plv = 0; flush = 0;
    step(); step();
    rst = 1'b0;

    // Reset state
    chk("rst.flat",   96'(dmw_flat),   96'h0);
    chk("rst.rvalid", 96'(csr_rvalid), 96'h0);
    chk("rst.rdata",  96'(csr_rdata),  96'h0);
    resp("rst", 0, 0, 0, 0, 32'h0, 0);

    // Read every index after reset, including out-of-range 3
    for (int i = 0; i < 4; i++) begin
      csr_re = 1'b1; csr_ridx = IW'(i);
      step();
      chk("rd_rst.rvalid", 96'(csr_rvalid), 96'h1);
      chk("rd_rst.rdata",  96'(csr_rdata),  96'h0);
    end
    csr_re = 1'b0;
    step();
    chk("rd_idle.rvalid", 96'(csr_rvalid), 96'h0);

    // Write all ones: only mask bits survive
    wr(0, 32'hFFFF_FFFF);
    chk("wr_ones.flat", 96'(dmw_flat), {32'h0, 32'h0, 32'hEE00_0039});
    csr_re = 1'b1; csr_ridx = 0;
    step();
    csr_re = 1'b0;
    chk("rd_ones", 96'(csr_rdata), 96'hEE00_0039);
    step();
    chk("rd_hold.rvalid", 96'(csr_rvalid), 96'h0);
    chk("rd_hold.rdata",  96'(csr_rdata),  96'hEE00_0039);

    // Same-cycle write and read: 0x12345678 & 0xEE000039 = 0x02000038 (bit 25 survives)
    csr_we = 1'b1; csr_widx = 0; csr_wdata = 32'h1234_5678;
    csr_re = 1'b1; csr_ridx = 0;
    step();
    csr_we = 1'b0; csr_re = 1'b0;
    chk("rd_wfirst", 96'(csr_rdata), 96'h0200_0038);

    // Single window hit, PLV0 only
    wr(0, 32'hA000_0011);
    req_valid = 1'b1; req_vaddr = 32'hA000_1234; req_plv = 2'd0;
    step();
    resp("hit_plv0", 1, 1, 0, 0, 32'h0000_1234, 2'd1);
    req_plv = 2'd3;
    step();
    resp("miss_plv3", 1, 0, 0, 0, 32'hA000_1234, 2'd0);
    req_plv = 2'd1;
    step();
    resp("miss_plv1", 1, 0, 0, 0, 32'hA000_1234, 2'd0);
    req_valid = 1'b0;

    // Two windows on the same VSEG
    wr(0, 32'h8000_0001);
    wr(1, 32'h8200_0019);
    req_valid = 1'b1; req_vaddr = 32'h8000_0040; req_plv = 2'd0;
    step();
    resp("multi_plv0", 1, 1, 1, 0, 32'h0000_0040, 2'd0);
    req_plv = 2'd3;
    step();
    // PSEG of window1 is 3'b001, placed at paddr[31:29]
    resp("single_plv3", 1, 1, 0, 1, 32'h2000_0040, 2'd1);
    req_valid = 1'b0;

    // Lookup sees pre-write contents
    wr(1, 32'h0);
    csr_we = 1'b1; csr_widx = 0; csr_wdata = 32'h0;
    req_valid = 1'b1; req_vaddr = 32'h8000_0040; req_plv = 2'd0;
    step();
    csr_we = 1'b0;
    resp("old_win", 1, 1, 0, 0, 32'h0000_0040, 2'd0);
    step();
    resp("new_win", 1, 0, 0, 0, 32'h8000_0040, 2'd0);
    req_valid = 1'b0;

    // Flush kills only the request of its own cycle; data fields hold
    wr(0, 32'hA000_0011);
    req_valid = 1'b1; req_plv = 2'd0; req_vaddr = 32'hA000_1234;
    step();
    resp("fl_c1", 1, 1, 0, 0, 32'h0000_1234, 2'd1);
    flush = 1'b1; req_vaddr = 32'hA000_5678;
    step();
    resp("fl_c2", 0, 1, 0, 0, 32'h0000_1234, 2'd1);
    flush = 1'b0; req_vaddr = 32'hA000_9999;
    step();
    resp("fl_c3", 1, 1, 0, 0, 32'h0000_9999, 2'd1);
    req_valid = 1'b0;
    step();
    resp("idle_hold", 0, 1, 0, 0, 32'h0000_9999, 2'd1);

    // Out-of-range write and read
    wr(3, 32'hFFFF_FFFF);
    chk("oor_wr.flat", 96'(dmw_flat), {32'h0, 32'h0, 32'hA000_0011});
    csr_re = 1'b1; csr_ridx = 3;
    step();
    csr_re = 1'b0;
    chk("oor_rd", 96'(csr_rdata), 96'h0);

    // Reset in the middle of a hitting request
    req_valid = 1'b1; req_vaddr = 32'hA000_4444; req_plv = 2'd0;
    #3 rst = 1'b1;
    #1;
    resp("rst_async", 0, 0, 0, 0, 32'h0, 2'd0);
    step();
    req_valid = 1'b0;
    rst = 1'b0;
    resp("rst_mid", 0, 0, 0, 0, 32'h0, 2'd0);
    chk("rst_mid.flat", 96'(dmw_flat), 96'h0);
    step();
    chk("rst_after.valid", 96'(resp_valid), 96'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
